irq_arbiter: RTL
================

# irq_arbiter

Multi-source interrupt controller between the board's event sources (PS/2 keyboard, breakpoint unit, IR debug, spare) and the single `irq`/`turnOffIRQ`/`intData`/`intAddr` interface of the CPU. It synchronises asynchronous source levels and latches rising edges into per-source pending bits with captured data. It arbitrates by fixed priority and presents one request at a time to the CPU, holding it until the CPU acknowledges. It replaces ad-hoc per-source IRQ logic in the top level.

## Interface
Parameters:
- `NSRC`, 4, number of sources; index 0 is the highest priority.
- `DW`, 16, source/interrupt data width.
- `AW`, 32, vector address width.
- `VEC_STRIDE`, 4, address step between per-source vectors.
- `HOLDOFF`, 2, idle cycles forced after each acknowledge (≥1).

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `srcLevel` in NSRC: raw event levels, asynchronous to `clk`; a rising edge is one event.
- `srcData` in NSRC*DW: per-source payload; source i occupies `[i*DW +: DW]`. It must be stable from the level rising until 3 cycles later.
- `srcMask` in NSRC: 1 = source eligible for arbitration.
- `intEn` in 1: global arbitration enable.
- `vectorBase` in AW: base of the vector table.
- `turnOffIRQ` in 1: CPU acknowledge pulse.
- `clrOvf` in NSRC: per-source overflow clear pulse.
- `irq` out 1: interrupt request to the CPU.
- `intData` out DW: payload of the active interrupt.
- `intAddr` out AW: vector of the active interrupt.
- `activeSrc` out clog2(NSRC): index of the active or last source.
- `pending` out NSRC: latched, not yet serviced events.
- `overflow` out NSRC: sticky flag for an event lost while its source was already pending.

## Operation
- Per source: a 2-FF synchroniser, then a rising-edge detect (sync level high, previous low) gives `evt[i]`, a one-cycle pulse.
- When `evt[i]` fires and `pending[i]`=0: set `pending[i]` and capture `srcData[i]` into `dataReg[i]`.
- When `evt[i]` fires and `pending[i]`=1: set `overflow[i]`. `dataReg[i]` keeps the first payload.
- `clrOvf[i]` clears `overflow[i]`. If a set and a clear occur in the same cycle, the set wins.
- Masked sources still latch pending and overflow; they are only excluded from arbitration.
- Eligible set: `pending & srcMask`, and only when `intEn`=1. The winner is the lowest set index.
- FSM states:
  - IDLE: if the eligible set is non-empty, go to GRANT.
  - GRANT (1 cycle): register the winner into `activeSrc`, `dataReg[w]` into `intData`, and `vectorBase + w*VEC_STRIDE` into `intAddr` (truncated to AW bits). Clear `pending[w]`. Go to ASSERT.
  - ASSERT: `irq`=1. When `turnOffIRQ`=1, go to HOLD and load the holdoff counter with HOLDOFF-1.
  - HOLD: `irq`=0. Decrement the counter; at 0, go to IDLE.
- If `evt[w]` occurs in the same GRANT cycle that clears `pending[w]`, the new event wins: pending stays 1 and the new data is captured.
- `turnOffIRQ` outside ASSERT is ignored.
- Once the FSM is in GRANT or ASSERT, the request is committed. Dropping `intEn` or `srcMask` then has no effect until the acknowledge.
- `intData`, `intAddr` and `activeSrc` hold their values until the next GRANT.

## Timing
- Reset values: `irq`=0, `intData`=0, `intAddr`=0, `activeSrc`=0, `pending`=0, `overflow`=0, FSM=IDLE, synchronisers=0.
- Reset asserted in any state clears everything immediately. `irq` falls asynchronously.
- A source rising edge at cycle 0 sets `pending` by cycle 3 (2 sync stages, edge detect, latch).
- From `pending` visible with the FSM in IDLE: GRANT is the next cycle and `irq`=1 in the cycle after, so pending-to-irq latency is 2 cycles.
- `turnOffIRQ` sampled in cycle N drops `irq` in N+1. The earliest next `irq` is N+1+HOLDOFF+2.
- Back-to-back sources are serviced in priority order, one per acknowledge.

## Structure
- Package `irq_pkg`: FSM state enum (IDLE, GRANT, ASSERT, HOLD), default DW/AW/VEC_STRIDE constants, and a clog2 helper constant for the `activeSrc` width.
- Sub-module `irq_sync_edge`: one per source, containing the 2-FF synchroniser and rising-edge pulse. Generated NSRC times.
- Priority encoder, pending/overflow registers and the FSM live in `irq_arbiter`.

## Test plan
- Single event: source 2 rises with data 0x1234, vectorBase 0x8000 → `pending`=0100 by cycle 3, `irq`=1 two cycles later, `intData`=0x1234, `intAddr`=0x8008, `activeSrc`=2. Ack → `irq`=0 next cycle.
- Priority: sources 1 and 3 rise together → source 1 is serviced first. After ack plus HOLDOFF, source 3 is serviced with `intAddr`=base+12.
- Overflow: source 0 rises twice before it is granted → `overflow[0]`=1 and `intData` carries the first payload. `clrOvf[0]` → 0. A new event in the same cycle as `clrOvf` → stays 1.
- Masking/enable: `intEn`=0 with source 0 pending → `irq` stays 0 indefinitely. Raise `intEn` → `irq` after 2 cycles. Masked source 1 pending → never granted while unmasked source 2 is granted.
- Race: a new edge on source w lands exactly in its GRANT cycle → `pending[w]` remains 1 and a second interrupt with the new data follows.
- Reset mid-ASSERT: `rst` low while `irq`=1 → `irq`, `pending` and outputs are 0 immediately. After release, no spurious `irq` without new edges.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared types and defaults for the interrupt arbiter.
package irq_pkg;

   // Arbiter FSM states; exported on the fsmState debug port.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_ASSERT = 2'd2,
      ST_HOLD   = 2'd3
   } irq_state_t;

   localparam int DEF_NSRC       = 4;
   localparam int DEF_DW         = 16;
   localparam int DEF_AW         = 32;
   localparam int DEF_VEC_STRIDE = 4;
   localparam int DEF_HOLDOFF    = 2;

   // Width of a source index; a single source still needs one bit.
   function automatic int src_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_SRC_W = src_w(DEF_NSRC);

endpackage

// File: rtl/irq_arbiter_sync_edge.sv
// Per-source 2-FF synchroniser with a one-cycle rising-edge pulse.
module irq_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic evt
);

   logic meta;
   logic sync;
   logic prev;

   // Two synchroniser stages, then a delayed copy of the synced level for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= level;
         sync <= meta;
         prev <= sync;
      end
   end

   assign evt = sync & ~prev;

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source fixed-priority interrupt controller feeding a single CPU irq interface.
//
// CPU handshake: irq is the request (valid) and turnOffIRQ the acknowledge (ready).
// Once irq rises it stays high, with intData/intAddr/activeSrc stable, until
// turnOffIRQ is sampled high on a rising clk edge; that edge completes the transfer
// and irq is low from the next cycle. turnOffIRQ outside that window is ignored.
// Only reset can withdraw a request without an acknowledge.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int NSRC       = DEF_NSRC,
   parameter int DW         = DEF_DW,
   parameter int AW         = DEF_AW,
   parameter int VEC_STRIDE = DEF_VEC_STRIDE,
   parameter int HOLDOFF    = DEF_HOLDOFF,
   localparam int SW        = src_w(NSRC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NSRC-1:0]    srcLevel,
   input  logic [NSRC*DW-1:0] srcData,
   input  logic [NSRC-1:0]    srcMask,
   input  logic               intEn,
   input  logic [AW-1:0]      vectorBase,
   input  logic               turnOffIRQ,
   input  logic [NSRC-1:0]    clrOvf,
   output logic               irq,
   output logic [DW-1:0]      intData,
   output logic [AW-1:0]      intAddr,
   output logic [SW-1:0]      activeSrc,
   output logic [NSRC-1:0]    pending,
   output logic [NSRC-1:0]    overflow,
   output irq_state_t         fsmState
);

   localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   logic [NSRC-1:0] evt;
   logic [DW-1:0]   dataReg [NSRC];
   logic [NSRC-1:0] eligible;
   logic [NSRC-1:0] grantClr;
   logic [SW-1:0]   winner;
   logic [SW-1:0]   winReg;
   logic [CW-1:0]   holdCnt;
   logic [CW-1:0]   holdCntNext;
   irq_state_t      state;
   irq_state_t      stateNext;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      irq_sync_edge u_sync (
         .clk   (clk),
         .rst   (rst),
         .level (srcLevel[gi]),
         .evt   (evt[gi])
      );
   end

   assign eligible = intEn ? (pending & srcMask) : '0;
   assign fsmState = state;

   // Fixed priority: the lowest eligible index wins.
   always_comb begin
      winner = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = SW'(i);
      end
   end

   // One-hot clear of the granted source's pending bit during GRANT.
   always_comb begin
      grantClr = '0;
      if (state == ST_GRANT) grantClr[winReg] = 1'b1;
   end

   // Pending/overflow/payload latch; a new event beats the grant clear, and an overflow set beats clrOvf.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending  <= '0;
         overflow <= '0;
         for (int i = 0; i < NSRC; i++) dataReg[i] <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (evt[i] && (!pending[i] || grantClr[i])) begin
               pending[i] <= 1'b1;
               dataReg[i] <= srcData[i*DW +: DW];
            end else if (grantClr[i]) begin
               pending[i] <= 1'b0;
            end
            if (evt[i] && pending[i] && !grantClr[i]) overflow[i] <= 1'b1;
            else if (clrOvf[i])                       overflow[i] <= 1'b0;
         end
      end
   end

   // Winner is frozen on leaving IDLE so the request is committed; outputs load in GRANT and hold after.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         winReg    <= '0;
         activeSrc <= '0;
         intData   <= '0;
         intAddr   <= '0;
      end else begin
         if (state == ST_IDLE && |eligible) winReg <= winner;
         if (state == ST_GRANT) begin
            activeSrc <= winReg;
            intData   <= dataReg[winReg];
            intAddr   <= vectorBase + (AW'(winReg) * AW'(VEC_STRIDE));
         end
      end
   end

   // FSM state and holdoff counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         holdCnt <= '0;
      end else begin
         state   <= stateNext;
         holdCnt <= holdCntNext;
      end
   end

   // Next-state logic; irq is decoded from ASSERT so reset drops it asynchronously.
   always_comb begin
      stateNext   = state;
      holdCntNext = holdCnt;
      irq         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|eligible) stateNext = ST_GRANT;
         end
         ST_GRANT: begin
            stateNext = ST_ASSERT;
         end
         ST_ASSERT: begin
            irq = 1'b1;
            if (turnOffIRQ) begin
               stateNext   = ST_HOLD;
               holdCntNext = CW'(HOLDOFF - 1);
            end
         end
         ST_HOLD: begin
            if (holdCnt == '0) stateNext = ST_IDLE;
            else               holdCntNext = holdCnt - CW'(1);
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
   end

endmodule
